// File: rtl/cordicg_chan_sched.sv
// Round-robin multi-channel front end and result tagger for the pipelined cordicg core.
// Define CORDIC_SCHED_GAINCOMP_EN to add a one-stage CORDIC gain-compensation multiplier on mag_o.
module cordicg_chan_sched #(
    parameter int WIDTH   = 19,
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int LATENCY = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         iq_valid_i,
    input  logic [NCH*WIDTH-1:0]   i_i,
    input  logic [NCH*WIDTH-1:0]   q_i,
    input  logic                   overrun_clr_i,
    output logic [1:0]             cordic_op_o,
    output logic [WIDTH-1:0]       cordic_x_o,
    output logic [WIDTH-1:0]       cordic_y_o,
    output logic [WIDTH:0]         cordic_ph_o,
    input  logic [WIDTH-1:0]       cordic_x_i,
    input  logic [WIDTH:0]         cordic_ph_i,
    output logic [WIDTH-1:0]       mag_o,
    output logic [WIDTH:0]         phase_o,
    output logic [CH_W-1:0]        ch_o,
    output logic                   valid_o,
    output logic [NCH-1:0]         overrun_o
);

    // The core samples cordic_x_o one edge after we launch it, so the tag needs
    // the launch register plus a LATENCY-deep delay line to meet its result.
    localparam int TAG_D = LATENCY + 1;

    logic [NCH-1:0][WIDTH-1:0] hold_i_q, hold_i_d, hold_q_q, hold_q_d;
    logic [NCH-1:0]            pending_q, pending_d;
    logic [NCH-1:0]            overrun_q, overrun_d;
    logic [CH_W-1:0]           rr_q, rr_d;
    logic [WIDTH-1:0]          cx_q, cx_d, cy_q, cy_d;
    logic [TAG_D-1:0]          tag_vld_q, tag_vld_d;
    logic [TAG_D-1:0][CH_W-1:0] tag_ch_q, tag_ch_d;
    logic [WIDTH-1:0]          mag_q, mag_d;
    logic [WIDTH:0]            phase_q, phase_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic                      valid_q, valid_d;

    logic                      found;
    logic [CH_W-1:0]           sel;

`ifdef CORDIC_SCHED_GAINCOMP_EN
    localparam int PW = WIDTH + 15;
    localparam logic signed [PW-1:0] GC_K    = PW'(19899);
    localparam logic signed [PW-1:0] GC_RND  = PW'(16384);
    localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    logic signed [PW-1:0] gc_prod_q, gc_prod_d;
    logic [WIDTH:0]       gc_ph_q, gc_ph_d;
    logic [CH_W-1:0]      gc_ch_q, gc_ch_d;
    logic                 gc_vld_q, gc_vld_d;

    function automatic logic [WIDTH-1:0] sat_shift(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> 15;
        if (s > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
        else if (s < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        return s[WIDTH-1:0];
    endfunction
`endif

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NCH) s = s - NCH;
        return CH_W'(s);
    endfunction

    // Scan downward so the last hit is the first pending channel at or after rr.
    always_comb begin
        found = 1'b0;
        sel   = rr_q;
        for (int off = NCH - 1; off >= 0; off--) begin
            if (pending_q[wrap_add(rr_q, off)]) begin
                found = 1'b1;
                sel   = wrap_add(rr_q, off);
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        hold_i_d  = hold_i_q;
        hold_q_d  = hold_q_q;
        pending_d = pending_q;
        overrun_d = overrun_clr_i ? '0 : overrun_q;
        rr_d      = rr_q;
        cx_d      = '0;
        cy_d      = '0;

        if (found) begin
            pending_d[sel] = 1'b0;
            rr_d           = (sel == CH_W'(NCH - 1)) ? '0 : sel + CH_W'(1);
            cx_d           = hold_i_q[sel];
            cy_d           = hold_q_q[sel];
        end

        // A strobe on the issuing channel refills it without counting as an overrun.
        for (int k = 0; k < NCH; k++) begin
            if (iq_valid_i[k]) begin
                hold_i_d[k]  = i_i[k*WIDTH +: WIDTH];
                hold_q_d[k]  = q_i[k*WIDTH +: WIDTH];
                if (pending_q[k] && !(found && sel == CH_W'(k)))
                    overrun_d[k] = 1'b1;
                pending_d[k] = 1'b1;
            end
        end

        tag_vld_d = {tag_vld_q[TAG_D-2:0], found};
        tag_ch_d  = {tag_ch_q[TAG_D-2:0], sel};
    end

    always_comb begin
        mag_d   = mag_q;
        phase_d = phase_q;
        ch_d    = ch_q;
`ifdef CORDIC_SCHED_GAINCOMP_EN
        gc_prod_d = gc_prod_q;
        gc_ph_d   = gc_ph_q;
        gc_ch_d   = gc_ch_q;
        gc_vld_d  = tag_vld_q[TAG_D-1];
        if (tag_vld_q[TAG_D-1]) begin
            gc_prod_d = PW'($signed(cordic_x_i)) * GC_K + GC_RND;
            gc_ph_d   = cordic_ph_i;
            gc_ch_d   = tag_ch_q[TAG_D-1];
        end
        valid_d = gc_vld_q;
        if (gc_vld_q) begin
            mag_d   = sat_shift(gc_prod_q);
            phase_d = gc_ph_q;
            ch_d    = gc_ch_q;
        end
`else
        valid_d = tag_vld_q[TAG_D-1];
        if (tag_vld_q[TAG_D-1]) begin
            mag_d   = cordic_x_i;
            phase_d = cordic_ph_i;
            ch_d    = tag_ch_q[TAG_D-1];
        end
`endif
    end

    // NOTE: the tag line is reset, the core is not; validity comes only from the tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_i_q  <= '0;
            hold_q_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            rr_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            tag_vld_q <= '0;
            tag_ch_q  <= '0;
            mag_q     <= '0;
            phase_q   <= '0;
            ch_q      <= '0;
            valid_q   <= 1'b0;
`ifdef CORDIC_SCHED_GAINCOMP_EN
            gc_prod_q <= '0;
            gc_ph_q   <= '0;
            gc_ch_q   <= '0;
            gc_vld_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            hold_i_q  <= hold_i_d;
            hold_q_q  <= hold_q_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_q      <= rr_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            tag_vld_q <= tag_vld_d;
            tag_ch_q  <= tag_ch_d;
            mag_q     <= mag_d;
            phase_q   <= phase_d;
            ch_q      <= ch_d;
            valid_q   <= valid_d;
`ifdef CORDIC_SCHED_GAINCOMP_EN
            gc_prod_q <= gc_prod_d;
            gc_ph_q   <= gc_ph_d;
            gc_ch_q   <= gc_ch_d;
            gc_vld_q  <= gc_vld_d;
`endif
        end
    end

    assign cordic_op_o = 2'b01;
    assign cordic_x_o  = cx_q;
    assign cordic_y_o  = cy_q;
    assign cordic_ph_o = '0;
    assign mag_o       = mag_q;
    assign phase_o     = phase_q;
    assign ch_o        = ch_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;

endmodule
